// File: rtl/cci_mpf_shim_req_arb.sv
// Two-requester round-robin read-request arbiter in front of the MPF pipeline.
// It tags requests with the requester ID, routes responses back by that tag and tracks outstanding requests.
module cci_mpf_shim_req_arb #(
  parameter int unsigned ADDR_WIDTH  = 42,
  parameter int unsigned MDATA_WIDTH = 16,
  parameter int unsigned TAG_IDX     = 15,
  parameter int unsigned MAX_ACTIVE  = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [ADDR_WIDTH-1:0]  req0_addr,
  input  logic [MDATA_WIDTH-1:0] req0_mdata,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [ADDR_WIDTH-1:0]  req1_addr,
  input  logic [MDATA_WIDTH-1:0] req1_mdata,
  output logic                   req1_ready,
  output logic                   out_valid,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic [MDATA_WIDTH-1:0] out_mdata,
  input  logic                   out_almfull,
  input  logic                   rsp_valid,
  input  logic [MDATA_WIDTH-1:0] rsp_mdata,
  input  logic [511:0]           rsp_data,
  output logic                   rsp0_valid,
  output logic                   rsp1_valid,
  output logic [MDATA_WIDTH-1:0] rsp_mdata_o,
  output logic [511:0]           rsp_data_o,
  output logic [7:0]             active0,
  output logic [7:0]             active1,
  output logic                   err_underflow
);

  localparam int unsigned CNT_W = 8;

  logic                   ptr;
  logic                   elig0, elig1;
  logic                   gnt0, gnt1;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [MDATA_WIDTH-1:0] sel_mdata;
  logic [MDATA_WIDTH-1:0] rsp_mdata_clr;
  logic                   dec0, dec1;
  logic [CNT_W-1:0]       active0_nxt, active1_nxt;
  logic                   underflow_c;

  // Counter step: accept and response in the same cycle cancel; never wrap below zero.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c,
                                                 input logic inc, input logic dec);
    logic [CNT_W-1:0] n;
    n = c;
    if (inc && !dec)
      n = c + CNT_W'(1);
    else if (dec && !inc && (c != '0))
      n = c - CNT_W'(1);
    return n;
  endfunction

  // Grant selection, tag insertion and response decode.
  always_comb begin
    elig0 = req0_valid && !out_almfull && (active0 < CNT_W'(MAX_ACTIVE));
    elig1 = req1_valid && !out_almfull && (active1 < CNT_W'(MAX_ACTIVE));
    gnt0  = elig0 && (!elig1 || !ptr);
    gnt1  = elig1 && (!elig0 || ptr);

    sel_addr           = gnt1 ? req1_addr : req0_addr;
    sel_mdata          = gnt1 ? req1_mdata : req0_mdata;
    sel_mdata[TAG_IDX] = gnt1;

    rsp_mdata_clr          = rsp_mdata;
    rsp_mdata_clr[TAG_IDX] = 1'b0;
    dec0 = rsp_valid && !rsp_mdata[TAG_IDX];
    dec1 = rsp_valid &&  rsp_mdata[TAG_IDX];

    active0_nxt = next_cnt(active0, gnt0, dec0);
    active1_nxt = next_cnt(active1, gnt1, dec1);
    underflow_c = (dec0 && (active0 == '0)) || (dec1 && (active1 == '0));
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Request path and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_mdata <= '0;
    end else begin
      out_valid <= gnt0 || gnt1;
      if (gnt0 || gnt1) begin
        out_addr  <= sel_addr;
        out_mdata <= sel_mdata;
        ptr       <= gnt0;
      end
    end
  end

  // Response path, outstanding counters and sticky underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid    <= 1'b0;
      rsp1_valid    <= 1'b0;
      rsp_mdata_o   <= '0;
      rsp_data_o    <= '0;
      active0       <= '0;
      active1       <= '0;
      err_underflow <= 1'b0;
    end else begin
      rsp0_valid <= dec0;
      rsp1_valid <= dec1;
      if (rsp_valid) begin
        rsp_mdata_o <= rsp_mdata_clr;
        rsp_data_o  <= rsp_data;
      end
      active0 <= active0_nxt;
      active1 <= active1_nxt;
      if (underflow_c)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cci_mpf_shim_req_arb.sv
// Directed bench for cci_mpf_shim_req_arb: per-cycle vector table plus a mid-operation reset sequence.
module tb_cci_mpf_shim_req_arb;

  localparam int unsigned AW = 42;
  localparam int unsigned MW = 16;
  localparam int unsigned NV = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, out_addr;
  logic [MW-1:0] req0_mdata, req1_mdata, out_mdata;
  logic          out_valid, out_almfull;
  logic          rsp_valid, rsp0_valid, rsp1_valid;
  logic [MW-1:0] rsp_mdata, rsp_mdata_o;
  logic [511:0]  rsp_data, rsp_data_o;
  logic [7:0]    active0, active1;
  logic          err_underflow;

  cci_mpf_shim_req_arb #(
    .ADDR_WIDTH(AW), .MDATA_WIDTH(MW), .TAG_IDX(15), .MAX_ACTIVE(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_mdata(req0_mdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_mdata(req1_mdata), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_mdata(out_mdata), .out_almfull(out_almfull),
    .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_mdata_o(rsp_mdata_o), .rsp_data_o(rsp_data_o),
    .active0(active0), .active1(active1), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r0v, r1v, alm, rspv;
    logic [15:0] rspm;
    logic       g0, g1, ersp0, ersp1, eerr;
    logic [7:0] a0, a1;
  } vec_t;

  vec_t vt[NV];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; out_almfull = 1'b0;
    rsp_valid = 1'b0; rsp_mdata = '0; rsp_data = '0;
    req0_addr = '0; req1_addr = '0; req0_mdata = '0; req1_mdata = '0;
  endtask

  initial begin
    // r0v r1v alm rspv rspm | g0 g1 rsp0 rsp1 err a0 a1
    vt[0]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0, 8'd1,8'd0};
    vt[1]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 1'b0,1'b1,1'b0,1'b0,1'b0, 8'd1,8'd1};
    vt[2]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0, 8'd2,8'd1};
    vt[3]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 1'b0,1'b1,1'b0,1'b0,1'b0, 8'd2,8'd2};
    vt[4]  = '{1'b1,1'b1,1'b1,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0, 8'd2,8'd2};
    vt[5]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0, 8'd3,8'd2};
    vt[6]  = '{1'b1,1'b0,1'b0,1'b1,16'h0003, 1'b1,1'b0,1'b1,1'b0,1'b0, 8'd3,8'd2};
    vt[7]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,1'b0,1'b0,1'b0,1'b0, 8'd4,8'd2};
    vt[8]  = '{1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b0, 8'd4,8'd2};
    vt[9]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 1'b0,1'b1,1'b0,1'b0,1'b0, 8'd4,8'd3};
    vt[10] = '{1'b0,1'b0,1'b0,1'b1,16'h8005, 1'b0,1'b0,1'b0,1'b1,1'b0, 8'd4,8'd2};
    vt[11] = '{1'b0,1'b0,1'b0,1'b1,16'h8005, 1'b0,1'b0,1'b0,1'b1,1'b0, 8'd4,8'd1};
    vt[12] = '{1'b0,1'b0,1'b0,1'b1,16'h8005, 1'b0,1'b0,1'b0,1'b1,1'b0, 8'd4,8'd0};
    vt[13] = '{1'b0,1'b0,1'b0,1'b1,16'h8007, 1'b0,1'b0,1'b0,1'b1,1'b1, 8'd4,8'd0};
    vt[14] = '{1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,1'b0,1'b1, 8'd4,8'd0};
    vt[15] = '{1'b1,1'b1,1'b0,1'b0,16'h0000, 1'b0,1'b1,1'b0,1'b0,1'b1, 8'd4,8'd1};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 512'(out_valid), 512'(1'b0));
    chk("rst active0", 512'(active0), 512'(8'd0));
    chk("rst active1", 512'(active1), 512'(8'd0));
    chk("rst err", 512'(err_underflow), 512'(1'b0));
    chk("rst rsp_valid", 512'({rsp0_valid, rsp1_valid}), 512'(2'b00));
    chk("rst out_mdata", 512'(out_mdata), 512'(16'h0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < int'(NV); i++) begin
      logic [MW-1:0] exp_md;
      logic [AW-1:0] exp_ad;
      @(negedge clk);
      req0_valid  = vt[i].r0v;
      req1_valid  = vt[i].r1v;
      out_almfull = vt[i].alm;
      rsp_valid   = vt[i].rspv;
      rsp_mdata   = vt[i].rspm;
      rsp_data    = {16{32'hA500_0000 | 32'(i)}};
      req0_addr   = AW'(32'h100 + 32'(i));
      req1_addr   = AW'(32'h200 + 32'(i));
      req0_mdata  = 16'h8000 | 16'(i);
      req1_mdata  = 16'h0000 | 16'(i);
      #1;
      chk($sformatf("v%0d req0_ready", i), 512'(req0_ready), 512'(vt[i].g0));
      chk($sformatf("v%0d req1_ready", i), 512'(req1_ready), 512'(vt[i].g1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 512'(out_valid), 512'(vt[i].g0 | vt[i].g1));
      chk($sformatf("v%0d active0", i), 512'(active0), 512'(vt[i].a0));
      chk($sformatf("v%0d active1", i), 512'(active1), 512'(vt[i].a1));
      chk($sformatf("v%0d rsp0_valid", i), 512'(rsp0_valid), 512'(vt[i].ersp0));
      chk($sformatf("v%0d rsp1_valid", i), 512'(rsp1_valid), 512'(vt[i].ersp1));
      chk($sformatf("v%0d err_underflow", i), 512'(err_underflow), 512'(vt[i].eerr));
      if (vt[i].g0 || vt[i].g1) begin
        exp_md = vt[i].g1 ? (16'h8000 | 16'(i)) : 16'(i);
        exp_ad = vt[i].g1 ? AW'(32'h200 + 32'(i)) : AW'(32'h100 + 32'(i));
        chk($sformatf("v%0d out_mdata", i), 512'(out_mdata), 512'(exp_md));
        chk($sformatf("v%0d out_addr", i), 512'(out_addr), 512'(exp_ad));
      end
      if (vt[i].rspv) begin
        chk($sformatf("v%0d rsp_mdata_o", i), 512'(rsp_mdata_o), 512'(vt[i].rspm & 16'h7FFF));
        chk($sformatf("v%0d rsp_data_o", i), rsp_data_o, {16{32'hA500_0000 | 32'(i)}});
      end
    end

    // Mid-operation reset: state is busy (a0=4, a1=1, err set) and a request is in flight.
    @(negedge clk);
    idle_inputs();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req1_addr = AW'(32'h777); req1_mdata = 16'h0042;
    @(posedge clk);
    #1;
    chk("pre-rst out_valid", 512'(out_valid), 512'(1'b1));
    chk("pre-rst active1", 512'(active1), 512'(8'd2));
    #2;
    reset = 1'b1;
    #1;
    chk("async rst out_valid", 512'(out_valid), 512'(1'b0));
    chk("async rst out_addr", 512'(out_addr), 512'(AW'(0)));
    chk("async rst active0", 512'(active0), 512'(8'd0));
    chk("async rst active1", 512'(active1), 512'(8'd0));
    chk("async rst err", 512'(err_underflow), 512'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    req0_addr = AW'(32'h555); req0_mdata = 16'h8011;
    #1;
    chk("fresh req0_ready", 512'(req0_ready), 512'(1'b1));
    chk("fresh req1_ready", 512'(req1_ready), 512'(1'b0));
    @(posedge clk);
    #1;
    chk("fresh out_valid", 512'(out_valid), 512'(1'b1));
    chk("fresh out_mdata", 512'(out_mdata), 512'(16'h0011));
    chk("fresh out_addr", 512'(out_addr), 512'(AW'(32'h555)));
    chk("fresh active0", 512'(active0), 512'(8'd1));
    @(negedge clk);
    #1;
    chk("fresh rr req1_ready", 512'(req1_ready), 512'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cci_mpf_shim_req_arb.md
CCI_MPF_SHIM_REQ_ARB -- requirements
Module: cci_mpf_shim_req_arb

Interface
REQ-001 Parameter: ADDR_WIDTH, default 42, request line-address width.
REQ-002 Parameter: MDATA_WIDTH, default 16, request/response Mdata width.
REQ-003 Parameter: TAG_IDX, default 15, Mdata bit position carrying the requester ID; SHALL be in the range 0..MDATA_WIDTH-1.
REQ-004 Parameter: MAX_ACTIVE, default 64, per-requester outstanding-request limit; SHALL be in the range 1..255.
REQ-005 Port: clk, in, 1, sole clock; all state changes on its rising edge.
REQ-006 Port: reset, in, 1, asynchronous, active-high.
REQ-007 Port: req0_valid / req1_valid, in, 1 each, requester n presents a read request.
REQ-008 Port: req0_addr / req1_addr, in, ADDR_WIDTH each, request line address.
REQ-009 Port: req0_mdata / req1_mdata, in, MDATA_WIDTH each, requester Mdata; bit TAG_IDX is ignored.
REQ-010 Port: req0_ready / req1_ready, out, 1 each, combinational grant; a request is accepted when valid and ready are both high.
REQ-011 Port: out_valid, out, 1, registered request toward the MPF pipeline.
REQ-012 Port: out_addr, out, ADDR_WIDTH, registered request address.
REQ-013 Port: out_mdata, out, MDATA_WIDTH, registered request Mdata.
REQ-014 Port: out_almfull, in, 1, downstream almost-full; no accept while high.
REQ-015 Port: rsp_valid, in, 1, response from the MPF pipeline.
REQ-016 Port: rsp_mdata, in, MDATA_WIDTH, response Mdata.
REQ-017 Port: rsp_data, in, 512, response line data.
REQ-018 Port: rsp0_valid / rsp1_valid, out, 1 each, registered response to requester n.
REQ-019 Port: rsp_mdata_o, out, MDATA_WIDTH, registered response Mdata.
REQ-020 Port: rsp_data_o, out, 512, registered response data, shared by both requesters.
REQ-021 Port: active0 / active1, out, 8 each, outstanding-request count per requester.
REQ-022 Port: err_underflow, out, 1, sticky flag for a response to an idle requester.

Function
REQ-023 Eligibility: requester n is eligible when req_n_valid && !out_almfull && active_n < MAX_ACTIVE.
REQ-024 Round-robin arbitration:
- pointer ptr, 1 bit;
- if both requesters are eligible, grant goes to ptr;
- if one is eligible, grant goes to it;
- at most one ready per cycle.
REQ-025 After any accept, ptr SHALL become the ID of the non-granted requester.
REQ-026 Request latency: 1 cycle.
- Accept at cycle t → out_valid=1 at t+1, with out_addr = the accepted address and out_mdata = the accepted Mdata with bit TAG_IDX replaced by the requester ID.
- No accept at t → out_valid=0 at t+1.
REQ-027 Response routing: rsp_valid at t → at t+1, rsp{rsp_mdata[TAG_IDX]}_valid=1, rsp_mdata_o = rsp_mdata with bit TAG_IDX forced to 0, and rsp_data_o = rsp_data.
REQ-028 Counter update: active_n increments on an accept by n and decrements on a response routed to n.
- Simultaneous increment and decrement → unchanged.
- Counters saturate at neither bound via wrap; increment is blocked by REQ-023.
REQ-029 Underflow: a response routed to n while active_n==0 SHALL set err_underflow and leave active_n at 0; the response is still forwarded.
REQ-030 A requester at active_n==MAX_ACTIVE SHALL be skipped without moving ptr; the other requester may be granted.
REQ-031 out_almfull takes effect in the same cycle: ready is 0 while it is high, and requests already registered still issue.

Reset
REQ-032 While reset is high:
- out_valid, rsp0_valid, rsp1_valid = 0;
- active0, active1 = 0;
- err_underflow = 0; ptr = 0;
- out_addr, out_mdata, rsp_mdata_o, rsp_data_o = 0.
REQ-033 Reset asserted mid-operation SHALL discard the registered request and response and clear the counters; the first cycle after deassertion behaves as a fresh start.

Verification
REQ-034 Both requesters valid continuously, out_almfull=0 → grants alternate 0,1,0,1; out_mdata[15] alternates 0,1; active0 = active1 = 2 after 4 cycles.
REQ-035 MAX_ACTIVE=4, req0 valid for 6 cycles, no responses → 4 accepts, then req0_ready=0 with active0=4; req1 is still granted when valid.
REQ-036 Response with rsp_mdata=16'h8005 → next cycle rsp1_valid=1, rsp_mdata_o=16'h0005; active1 decrements by 1.
REQ-037 Accept by req0 and a response to req0 in the same cycle with active0=3 → active0 stays 3.
REQ-038 Response to req1 with active1=0 → err_underflow=1 and stays 1 until reset; active1=0.
REQ-039 out_almfull=1 with both requests valid → ready=0, out_valid=0 from the next cycle; deassertion → grant to ptr in that cycle.
